rriot_bus_master: RTL and testbench

RRIOT_BUS_MASTER -- requirements
Module: rriot_bus_master

---
 rtl/rriot_pkg.sv | 25 ++
 rtl/rriot_phase_gen.sv | 29 ++
 rtl/rriot_bus_master.sv | 168 ++++++++++++++++
 tb/tb_rriot_bus_master.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rriot_pkg.sv
// Shared types and limits for the RRIOT (6530/6532) bus master.
// Holds the FSM state enum, the latched bus-cycle bundle and counter widths.
package rriot_pkg;

   localparam int PHASE_MAX = 16;
   localparam int RES_MAX   = 255;
   localparam int PH_W      = $clog2(PHASE_MAX);
   localparam int RES_W     = $clog2(RES_MAX + 1);

   typedef enum logic [2:0] {
      RESET,
      IDLE,
      PH1,
      PH2,
      DONE
   } state_t;

   typedef struct packed {
      logic       we;
      logic [9:0] addr;
      logic       rs0;
      logic [7:0] wdata;
   } bus_cycle_t;

endpackage

// File: rtl/rriot_phase_gen.sv
// phi2 half-phase down-counter: load sets the count, tick decrements.
// Ports: clk, rst, load, load_val, tick in; tc (count == 0) out.
module rriot_phase_gen
   import rriot_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [PH_W-1:0] load_val,
   input  logic            tick,
   output logic            tc
);

   logic [PH_W-1:0] cnt;

   // Saturates at zero so a stray tick never wraps the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (tick && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/rriot_bus_master.sv
// Command-to-bus-cycle master for a 6530/6532 RRIOT: one phi2 cycle per cmd.
// Ports: cmd_* request handshake, rsp_* completion; phi2/r_w/addr/rs0/cs1/
// cs2/res_n/db_* drive the chip bus; irq_n in, irq out. Macro
// RRIOT_IRQ_SYNC_EN selects a two-flop irq synchronizer (else one flop).
module rriot_bus_master
   import rriot_pkg::*;
#(
   parameter int PHASE_CYCLES = 2,
   parameter int RES_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_we,
   input  logic [9:0] cmd_addr,
   input  logic       cmd_rs0,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       phi2,
   output logic       r_w,
   output logic [9:0] addr,
   output logic       rs0,
   output logic       cs1,
   output logic       cs2,
   output logic       res_n,
   output logic [7:0] db_o,
   output logic       db_oe,
   input  logic [7:0] db_i,
   input  logic       irq_n,
   output logic       irq
);

   localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(PHASE_CYCLES - 1);
   localparam logic [RES_W-1:0] RES_LOAD = RES_W'(RES_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   bus_cycle_t       cyc_q;
   logic [RES_W-1:0] res_cnt;
   logic [7:0]       rdata_q;
   logic             ph_load;
   logic             ph_tick;
   logic             ph_tc;

   rriot_phase_gen u_phase_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (ph_load),
      .load_val (PH_LOAD),
      .tick     (ph_tick),
      .tc       (ph_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RESET;
         res_cnt <= RES_LOAD;
         cyc_q   <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if ((state == RESET) && (res_cnt != '0)) begin
            res_cnt <= res_cnt - 1'b1;
         end
         if ((state == IDLE) && cmd_valid) begin
            cyc_q <= {cmd_we, cmd_addr, cmd_rs0, cmd_wdata};
         end
         // Edge that closes the last PH2 cycle: read data is valid here.
         if ((state == PH2) && ph_tc) begin
            rdata_q <= cyc_q.we ? 8'h00 : db_i;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ph_load   = 1'b0;
      ph_tick   = 1'b0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      phi2      = 1'b0;
      r_w       = 1'b1;
      cs1       = 1'b0;
      cs2       = 1'b1;
      db_oe     = 1'b0;
      res_n     = 1'b1;
      unique case (state)
         RESET: begin
            res_n = 1'b0;
            if (res_cnt == '0) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               ph_load   = 1'b1;
               state_nxt = PH1;
            end
         end
         PH1: begin
            r_w = ~cyc_q.we;
            cs1 = 1'b1;
            cs2 = 1'b0;
            if (ph_tc) begin
               ph_load   = 1'b1;
               state_nxt = PH2;
            end else begin
               ph_tick = 1'b1;
            end
         end
         PH2: begin
            phi2  = 1'b1;
            r_w   = ~cyc_q.we;
            cs1   = 1'b1;
            cs2   = 1'b0;
            db_oe = cyc_q.we;
            if (ph_tc) begin
               state_nxt = DONE;
            end else begin
               ph_tick = 1'b1;
            end
         end
         DONE: begin
            // Chip select, r_w and write data held one extra cycle.
            r_w       = ~cyc_q.we;
            cs1       = 1'b1;
            cs2       = 1'b0;
            db_oe     = cyc_q.we;
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = RESET;
         end
      endcase
   end

   assign db_o      = db_oe ? cyc_q.wdata : 8'h00;
   assign addr      = cyc_q.addr;
   assign rs0       = cyc_q.rs0;
   assign rsp_rdata = rdata_q;

`ifdef RRIOT_IRQ_SYNC_EN
   logic irq_meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_meta <= 1'b0;
         irq      <= 1'b0;
      end else begin
         irq_meta <= ~irq_n;
         irq      <= irq_meta;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         irq <= 1'b0;
      end else begin
         irq <= ~irq_n;
      end
   end
`endif

endmodule

// File: tb/tb_rriot_bus_master.sv
// Bench for rriot_bus_master: PHASE_CYCLES=2 and =1 instances share stimulus.
// A cycle-offset model checks every output each cycle; tasks pin literals.
module tb_rriot_bus_master;

   localparam int RES = 8;
   localparam int PC0 = 2;
   localparam int PC1 = 1;
`ifdef RRIOT_IRQ_SYNC_EN
   localparam int IRQ_LAT = 2;
`else
   localparam int IRQ_LAT = 1;
`endif

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_we    = 1'b0;
   logic [9:0] cmd_addr  = '0;
   logic       cmd_rs0   = 1'b0;
   logic [7:0] cmd_wdata = '0;
   logic [7:0] db_i      = '0;
   logic       irq_n     = 1'b1;

   logic       rdy   [2];
   logic       rv    [2];
   logic [7:0] rdata [2];
   logic       phi2  [2];
   logic       r_w   [2];
   logic [9:0] addr  [2];
   logic       rs0   [2];
   logic       cs1   [2];
   logic       cs2   [2];
   logic       res_n [2];
   logic [7:0] db_o  [2];
   logic       oe    [2];
   logic       irq   [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rriot_bus_master #(.PHASE_CYCLES(PC0), .RES_CYCLES(RES)) u0 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
      .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_rs0(cmd_rs0),
      .cmd_wdata(cmd_wdata), .rsp_valid(rv[0]), .rsp_rdata(rdata[0]),
      .phi2(phi2[0]), .r_w(r_w[0]), .addr(addr[0]), .rs0(rs0[0]),
      .cs1(cs1[0]), .cs2(cs2[0]), .res_n(res_n[0]), .db_o(db_o[0]),
      .db_oe(oe[0]), .db_i(db_i), .irq_n(irq_n), .irq(irq[0])
   );

   rriot_bus_master #(.PHASE_CYCLES(PC1), .RES_CYCLES(RES)) u1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
      .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_rs0(cmd_rs0),
      .cmd_wdata(cmd_wdata), .rsp_valid(rv[1]), .rsp_rdata(rdata[1]),
      .phi2(phi2[1]), .r_w(r_w[1]), .addr(addr[1]), .rs0(rs0[1]),
      .cs1(cs1[1]), .cs2(cs2[1]), .res_n(res_n[1]), .db_o(db_o[1]),
      .db_oe(oe[1]), .db_i(db_i), .irq_n(irq_n), .irq(irq[1])
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Model: reset countdown, plus edges elapsed since the accept edge.
   int         m_rst_left [2];
   bit         m_busy     [2];
   int         m_t        [2];
   logic       m_we       [2];
   logic [9:0] m_addr     [2];
   logic       m_rs0      [2];
   logic [7:0] m_wd       [2];
   logic [7:0] m_rd       [2];
   logic [1:0] m_ih       [2];
   bit         m_ok       [2];

   function automatic int pcof(input int i);
      return (i == 0) ? PC0 : PC1;
   endfunction

   task automatic model_step(input int i);
      int pc;
      pc = pcof(i);
      if (rst) begin
         m_ok[i]       = 1'b1;
         m_rst_left[i] = RES;
         m_busy[i]     = 1'b0;
         m_t[i]        = 0;
         m_we[i]       = 1'b0;
         m_addr[i]     = '0;
         m_rs0[i]      = 1'b0;
         m_wd[i]       = '0;
         m_rd[i]       = '0;
         m_ih[i]       = '0;
      end else begin
         m_ih[i] = {m_ih[i][0], ~irq_n};
         if (m_rst_left[i] > 0) begin
            m_rst_left[i]--;
         end else if (m_busy[i]) begin
            if (m_t[i] == 2 * pc - 1) m_rd[i] = m_we[i] ? 8'h00 : db_i;
            if (m_t[i] == 2 * pc) m_busy[i] = 1'b0;
            else m_t[i]++;
         end else if (cmd_valid) begin
            m_busy[i] = 1'b1;
            m_t[i]    = 0;
            m_we[i]   = cmd_we;
            m_addr[i] = cmd_addr;
            m_rs0[i]  = cmd_rs0;
            m_wd[i]   = cmd_wdata;
         end
      end
   endtask

   function automatic logic [35:0] expect_out(input int i);
      int   pc;
      int   t;
      logic b;
      logic inrst;
      logic e_oe;
      pc    = pcof(i);
      t     = m_t[i];
      b     = m_busy[i];
      inrst = (m_rst_left[i] > 0);
      e_oe  = b && m_we[i] && (t >= pc);
      return {!inrst && !b, b && (t == 2 * pc), m_rd[i],
              b && (t >= pc) && (t < 2 * pc), b ? ~m_we[i] : 1'b1,
              m_addr[i], m_rs0[i], b, !b, !inrst,
              e_oe ? m_wd[i] : 8'h00, e_oe, m_ih[i][IRQ_LAT-1]};
   endfunction

   function automatic logic [35:0] dut_vec(input int i);
      return {rdy[i], rv[i], rdata[i], phi2[i], r_w[i], addr[i], rs0[i],
              cs1[i], cs2[i], res_n[i], db_o[i], oe[i], irq[i]};
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) model_step(i);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (m_ok[i]) chk($sformatf("outs%0d", i), dut_vec(i), expect_out(i));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!rdy[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", rdy[0], 1'b1);
   endtask

   task automatic check_reset_seq();
      int low_n;
      int rdy_k;
      bit rv_seen;
      low_n   = 0;
      rdy_k   = -1;
      rv_seen = 1'b0;
      chk("rst_phi2", phi2[0], 1'b0);
      chk("rst_oe", oe[0], 1'b0);
      chk("rst_cs", {cs1[0], cs2[0]}, 2'b01);
      for (int k = 0; k < 14; k++) begin
         if (!res_n[0]) low_n++;
         if (rdy[0] && rdy_k < 0) rdy_k = k;
         if (rv[0]) rv_seen = 1'b1;
         @(negedge clk);
      end
      chk("res_n_low_cycles", low_n, RES);
      chk("ready_cycle", rdy_k, RES);
      chk("no_rsp_in_reset", rv_seen, 1'b0);
   endtask

   task automatic reset_seq();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_seq();
   endtask

   task automatic do_cmd(input logic we, input logic [9:0] a,
                         input logic rs, input logic [7:0] wd,
                         input logic [7:0] exp_rd);
      logic [5:0] phi_seq;
      logic [7:0] got_rd;
      int         oe_n;
      int         rw0_n;
      int         rsp_k;
      bit         od_ok;
      phi_seq = '0;
      got_rd  = '0;
      oe_n    = 0;
      rw0_n   = 0;
      rsp_k   = -1;
      od_ok   = 1'b1;
      @(negedge clk);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = a;
      cmd_rs0   = rs;
      cmd_wdata = wd;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            cmd_valid = 1'b0;
            chk("addr_latch", {rs0[0], addr[0]}, {rs, a});
         end
         if (k <= 5) phi_seq[k] = phi2[0];
         if (oe[0]) begin
            oe_n++;
            if (db_o[0] !== wd) od_ok = 1'b0;
         end
         if (!r_w[0]) rw0_n++;
         if (rv[0]) begin
            if (rsp_k < 0) rsp_k = k;
            got_rd = rdata[0];
         end
         if (k == 4 && !we) db_i = 8'hC3;
         if (k == 5) db_i = 8'h00;
      end
      chk("phi2_seq", phi_seq[5:1], 5'b01100);
      chk("rsp_latency", rsp_k, 5);
      chk("rsp_rdata", got_rd, exp_rd);
      chk("oe_cycles", oe_n, we ? 3 : 0);
      chk("rw_low_cycles", rw0_n, we ? 5 : 0);
      chk("db_o_value", od_ok, 1'b1);
   endtask

   task automatic mid_reset();
      bit rv_seen;
      rv_seen = 1'b0;
      @(negedge clk);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = 10'h155;
      cmd_rs0   = 1'b0;
      cmd_wdata = 8'hA5;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) cmd_valid = 1'b0;
         if (rv[0]) rv_seen = 1'b1;
      end
      chk("mid_in_ph2", {phi2[0], oe[0]}, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_no_rsp", rv_seen | rv[0], 1'b0);
      check_reset_seq();
   endtask

   task automatic b2b();
      int hs0[$];
      int hs1[$];
      int rp0[$];
      int rp1[$];
      int k;
      bit got;
      k = 0;
      @(negedge clk);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = 10'h0AA;
      cmd_rs0   = 1'b1;
      while (k < 40 && rp0.size() < 2) begin
         if (cmd_valid && rdy[0]) hs0.push_back(k);
         if (cmd_valid && rdy[1]) hs1.push_back(k);
         if (rv[0]) rp0.push_back(k);
         if (rv[1]) rp1.push_back(k);
         @(negedge clk);
         k++;
         if (hs0.size() >= 2) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      got = (hs0.size() >= 2) && (rp0.size() >= 2) &&
            (hs1.size() >= 2) && (rp1.size() >= 2);
      chk("b2b_events", got, 1'b1);
      if (got) begin
         chk("b2b_lat0_a", rp0[0] - hs0[0], 5);
         chk("b2b_lat0_b", rp0[1] - hs0[1], 5);
         chk("b2b_gap0", hs0[1] - rp0[0], 1);
         chk("b2b_lat1_a", rp1[0] - hs1[0], 3);
         chk("b2b_lat1_b", rp1[1] - hs1[1], 3);
         chk("b2b_gap1", hs1[1] - rp1[0], 1);
      end
   endtask

   task automatic irq_test();
      int k_rise;
      int k_fall;
      k_rise = -1;
      k_fall = -1;
      @(negedge clk);
      irq_n = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (irq[0] && k_rise < 0) k_rise = k;
      end
      irq_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (!irq[0] && k_fall < 0) k_fall = k;
      end
      chk("irq_rise_lat", k_rise, IRQ_LAT);
      chk("irq_fall_lat", k_fall, IRQ_LAT);
   endtask

   initial begin
      reset_seq();
      do_cmd(1'b1, 10'h201, 1'b1, 8'h5A, 8'h00);
      do_cmd(1'b0, 10'h3F0, 1'b0, 8'h00, 8'hC3);
      do_cmd(1'b1, 10'h000, 1'b0, 8'hFF, 8'h00);
      do_cmd(1'b0, 10'h3FF, 1'b1, 8'h77, 8'hC3);
      mid_reset();
      b2b();
      repeat (12) @(negedge clk);
      irq_test();
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
